// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - ROM fetch and datapath issue bus for fetch_sequencer
interface fetch_sequencer_if;
  logic [3:0]  address;
  logic [15:0] instruction;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [2:0]  issue_rd;
  logic [2:0]  issue_rs;
  logic [7:0]  issue_imm;
  logic        done;
  logic        zero;

  modport master (
    output address, issue_valid, issue_op, issue_rd, issue_rs, issue_imm,
    input  instruction, issue_ready, done, zero
  );

  modport slave (
    input  address, issue_valid, issue_op, issue_rd, issue_rs, issue_imm,
    output instruction, issue_ready, done, zero
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC/IR fetch sequencer: resolves nop/jmp/br, issues the rest
module fetch_sequencer #(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  fetch_sequencer_if.master         bus,
  output logic [3:0]                pc,
  output logic                      zf
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1000;
  localparam logic [3:0] OP_BR  = 4'b1100;

  typedef enum logic [1:0] {FETCH, ISSUE, WAIT} state_t;

  state_t      state;
  logic [3:0]  pc_q;
  logic [15:0] ir;
  logic        zf_q;
  logic        valid_q;

  function automatic logic is_local(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_JMP) || (op == OP_BR);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc_q    <= RESET_PC;
      ir      <= 16'h0000;
      zf_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (run) begin
            ir <= bus.instruction;
            // valid is decoded at the fetch edge so it is purely registered
            valid_q <= !is_local(bus.instruction[15:12]);
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_local(ir[15:12])) begin
            if (ir[15:12] == OP_JMP || (ir[15:12] == OP_BR && zf_q))
              pc_q <= ir[11:8];
            else
              pc_q <= pc_q + 4'd1;
            state <= FETCH;
          end else if (valid_q && bus.issue_ready) begin
            pc_q    <= pc_q + 4'd1;
            valid_q <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (bus.done) begin
            zf_q  <= bus.zero;
            state <= FETCH;
          end
        end
        default: begin
          state   <= FETCH;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.address     = pc_q;
  assign bus.issue_valid = valid_q;
  assign bus.issue_op    = ir[15:12];
  assign bus.issue_rd    = ir[11:9];
  assign bus.issue_rs    = ir[8:6];
  assign bus.issue_imm   = ir[7:0];
  assign pc              = pc_q;
  assign zf              = zf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized bench for fetch_sequencer with an instruction-level model
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [3:0] pc;
  logic       zf;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_PC(4'd0)) dut (
    .clk(clk), .rst(rst), .run(run), .bus(bus), .pc(pc), .zf(zf)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [16];
  assign bus.instruction = rom[bus.address];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: architectural PC, flag and register file
  logic [3:0] pc_m;
  logic       zf_m;
  logic [7:0] regs [8];
  int         issues_at [16];

  bit          exp_en = 1'b0;
  logic [3:0]  exp_addr;
  logic        exp_valid;
  logic        exp_zf;
  logic [15:0] exp_ir;

  always @(negedge clk) begin
    if (exp_en && !rst) begin
      check("address", 32'(bus.address), 32'(exp_addr));
      check("pc", 32'(pc), 32'(exp_addr));
      check("issue_valid", 32'(bus.issue_valid), 32'(exp_valid));
      check("zf", 32'(zf), 32'(exp_zf));
      if (exp_valid) begin
        check("issue_op", 32'(bus.issue_op), 32'(exp_ir[15:12]));
        check("issue_rd", 32'(bus.issue_rd), 32'(exp_ir[11:9]));
        check("issue_rs", 32'(bus.issue_rs), 32'(exp_ir[8:6]));
        check("issue_imm", 32'(bus.issue_imm), 32'(exp_ir[7:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    bus.done        = 1'($urandom);
    bus.zero        = 1'($urandom);
    bus.issue_ready = 1'($urandom);
  endtask

  task automatic do_reset();
    exp_en = 1'b0;
    rst = 1'b1; run = 1'b0;
    bus.issue_ready = 1'b0; bus.done = 1'b0; bus.zero = 1'b0;
    step(); step();
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_zf", 32'(zf), 32'd0);
    rst = 1'b0;
    pc_m = 4'd0; zf_m = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 8'd0;
    for (int i = 0; i < 16; i++) issues_at[i] = 0;
  endtask

  // Behavioural datapath: returns the zero flag the datapath reports
  task automatic dp_exec(input logic [15:0] ir, output logic z);
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] res;
    rd = ir[11:9];
    rs = ir[8:6];
    case (ir[15:12])
      4'h1: begin res = ir[7:0];             regs[rd] = res; end
      4'h2: begin res = regs[rd] + regs[rs]; regs[rd] = res; end
      4'h3: begin res = regs[rd] - regs[rs]; regs[rd] = res; end
      4'hB: begin res = regs[rd] - ir[7:0];  regs[rd] = res; end
      4'hE: begin res = regs[rs];            regs[rd] = res; end
      default: res = regs[rd];
    endcase
    z = (res == 8'd0);
  endtask

  task automatic exec_n(input int n, input int rmin, input int rmax,
                        input int dmin, input int dmax, input int gap_max);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ir_m;
      logic [3:0]  op;
      logic        z;
      int          k;
      ir_m = rom[pc_m];
      op   = ir_m[15:12];
      exp_en = 1'b1; exp_addr = pc_m; exp_valid = 1'b0; exp_zf = zf_m;
      k = int'($urandom_range(gap_max, 0));
      repeat (k) begin run = 1'b0; noise(); step(); end
      run = 1'b1; noise(); step();
      run = 1'($urandom);
      if (op == 4'h0 || op == 4'h8 || op == 4'hC) begin
        noise(); step();
        if (op == 4'h8 || (op == 4'hC && zf_m)) pc_m = ir_m[11:8];
        else pc_m = pc_m + 4'd1;
      end else begin
        exp_valid = 1'b1; exp_ir = ir_m;
        k = int'($urandom_range(rmax, rmin));
        repeat (k) begin
          bus.issue_ready = 1'b0; bus.done = 1'($urandom); bus.zero = 1'($urandom);
          step();
        end
        bus.issue_ready = 1'b1; bus.done = 1'($urandom); bus.zero = 1'($urandom);
        step();
        issues_at[pc_m]++;
        pc_m = pc_m + 4'd1;
        exp_addr = pc_m; exp_valid = 1'b0;
        dp_exec(ir_m, z);
        k = int'($urandom_range(dmax, dmin));
        repeat (k) begin
          bus.done = 1'b0; bus.zero = 1'($urandom); bus.issue_ready = 1'($urandom);
          step();
        end
        bus.done = 1'b1; bus.zero = z; bus.issue_ready = 1'($urandom);
        step();
        bus.done = 1'b0;
        zf_m = z;
      end
    end
    run = 1'b0; noise();
    exp_addr = pc_m; exp_valid = 1'b0; exp_zf = zf_m;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [3:0] seen;

    // Straight-line issue with hand-computed cycle expectations
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1E07;
    do_reset();
    run = 1'b1; bus.issue_ready = 1'b1;
    step();
    @(negedge clk);
    check("sl_valid_c2", 32'(bus.issue_valid), 32'd1);
    check("sl_op_c2", 32'(bus.issue_op), 32'd1);
    check("sl_rd_c2", 32'(bus.issue_rd), 32'd7);
    check("sl_imm_c2", 32'(bus.issue_imm), 32'h07);
    check("sl_addr_c2", 32'(bus.address), 32'd0);
    @(posedge clk); #1;
    bus.issue_ready = 1'b0; bus.done = 1'b1; bus.zero = 1'b0;
    check("sl_valid_c3", 32'(bus.issue_valid), 32'd0);
    step();
    bus.done = 1'b0; run = 1'b0;
    check("sl_addr_c4", 32'(bus.address), 32'd1);

    // Backpressure: five stalled cycles before acceptance
    do_reset();
    exec_n(1, 5, 5, 1, 1, 0);
    check("bp_pc_model", 32'(pc_m), 32'd1);

    // Jump from 5 back to 1 after nops
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[5] = 16'h8100;
    do_reset();
    exec_n(5, 0, 0, 0, 0, 0);
    check("jmp_addr_before", 32'(bus.address), 32'd5);
    exec_n(1, 0, 0, 0, 0, 0);
    check("jmp_addr_after", 32'(bus.address), 32'd1);
    check("jmp_no_issue", 32'(issues_at[5]), 32'd0);

    // Nop wrap from 15 to 0
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    do_reset();
    exec_n(15, 0, 0, 0, 0, 1);
    check("wrap_addr_15", 32'(bus.address), 32'd15);
    exec_n(1, 0, 0, 0, 0, 0);
    check("wrap_addr_0", 32'(bus.address), 32'd0);

    // Countdown program: both branch directions and loop alternation
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1E07; rom[1] = 16'hFE00; rom[2] = 16'hBE01; rom[3] = 16'hCA00;
    rom[4] = 16'hFE00; rom[5] = 16'h8100; rom[10] = 16'hF200; rom[11] = 16'h8A00;
    do_reset();
    guard = 0;
    while (pc_m != 4'd10 && guard < 100) begin
      exec_n(1, 0, 2, 0, 2, 1);
      guard++;
    end
    check("cd_bound", 32'(guard < 100), 32'd1);
    check("cd_out_r7_loop", 32'(issues_at[1]), 32'd7);
    check("cd_out_r7_fall", 32'(issues_at[4]), 32'd6);
    check("cd_r7_final", 32'(regs[7]), 32'd0);
    check("cd_br_taken_addr", 32'(bus.address), 32'd10);
    for (int j = 0; j < 6; j++) begin
      seen = bus.address;
      check("cd_alternate", 32'(seen), (j % 2 == 0) ? 32'd10 : 32'd11);
      exec_n(1, 0, 2, 0, 2, 0);
    end

    // Reset mid-WAIT with zf set, then idle with run low
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1E00; rom[1] = 16'h1E05;
    do_reset();
    exec_n(1, 0, 0, 0, 0, 0);
    exp_en = 1'b0;
    run = 1'b1; bus.issue_ready = 1'b1; bus.done = 1'b0;
    step();
    run = 1'b0;
    step();
    check("mw_zf_pre", 32'(zf), 32'd1);
    check("mw_addr_pre", 32'(bus.address), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mw_rst_addr", 32'(bus.address), 32'd0);
    check("mw_rst_valid", 32'(bus.issue_valid), 32'd0);
    check("mw_rst_zf", 32'(zf), 32'd0);
    step();
    rst = 1'b0; run = 1'b0; bus.issue_ready = 1'b1; bus.done = 1'b1; bus.zero = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_addr", 32'(bus.address), 32'd0);
      check("idle_valid", 32'(bus.issue_valid), 32'd0);
      check("idle_ir_op", 32'(bus.issue_op), 32'd0);
      check("idle_zf", 32'(zf), 32'd0);
    end
    bus.done = 1'b0;

    // Random programs with random handshake timing
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) rom[i] = 16'($urandom);
      do_reset();
      exec_n(150, 0, 3, 0, 3, 2);
    end
    exp_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
